// File: rtl/grid_draw_engine.sv
// ---------------------------------------------------------------------------
// grid_draw_engine
//
// Upstream writer for the GridData cell buffer (GRID_W x GRID_H cells,
// COLOR_W-bit colour index per cell) scanned by the VGA controller. Drawing
// commands arrive over a valid/ready handshake. Each command is expanded
// into one GridData write per clock on the buffer's only write port.
//
// Commands (cmd_op):
//   00 CLEAR      write every cell, address 0 .. GRID_W*GRID_H-1
//   01 SET        write the single cell (x0,y0)
//   10 FILL_RECT  row-major scan of the normalised rectangle
//   11 NOP        no writes, done pulse only
//      (OUTLINE when GRID_DRAW_OUTLINE_EN is defined: same scan as
//       FILL_RECT, but only perimeter cells are written)
//
// Optional feature macro: GRID_DRAW_OUTLINE_EN
//
// Ports:
//   clock, reset                   clock, synchronous active-high reset
//   cmd_valid / cmd_ready          command handshake
//   cmd_op, cmd_x0/x1, cmd_y0/y1   opcode and rectangle corners
//   cmd_color                      colour index written by the command
//   wren/wraddress/data_gridData   GridData write port (registered)
//   busy                           command in progress
//   done                           one-cycle pulse, command completed
//   cmd_err                        one-cycle pulse, command rejected
// ---------------------------------------------------------------------------
module grid_draw_engine #(
   parameter int GRID_W  = 64,
   parameter int GRID_H  = 48,
   parameter int ADDR_W  = 12,
   parameter int COLOR_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [5:0]         cmd_x0,
   input  logic [5:0]         cmd_x1,
   input  logic [5:0]         cmd_y0,
   input  logic [5:0]         cmd_y1,
   input  logic [COLOR_W-1:0] cmd_color,
   output logic               wren_gridData,
   output logic [ADDR_W-1:0]  wraddress_gridData,
   output logic [COLOR_W-1:0] data_gridData,
   output logic               busy,
   output logic               done,
   output logic               cmd_err
);

   localparam int CRD_W = 6;
   localparam int X_W   = $clog2(GRID_W);
   localparam logic [CRD_W-1:0] X_MAX = CRD_W'(GRID_W - 1);
   localparam logic [CRD_W-1:0] Y_MAX = CRD_W'(GRID_H - 1);

   typedef enum logic {S_IDLE, S_DRAW} state_t;
   typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_SET = 2'b01,
                             OP_FILL  = 2'b10, OP_EXT = 2'b11} op_t;

   // GRID_W is a power of two, so y*GRID_W + x is a shift-and-or.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [CRD_W-1:0] x,
                                                   input logic [CRD_W-1:0] y);
      return (ADDR_W'(y) << X_W) | ADDR_W'(x);
   endfunction

   state_t             state_q, state_d;
   logic [CRD_W-1:0]   x_q, y_q, x_d, y_d;
   logic [CRD_W-1:0]   x_lo_q, x_hi_q, y_lo_q, y_hi_q;
   logic [CRD_W-1:0]   x_lo_d, x_hi_d, y_lo_d, y_hi_d;
   logic               ready_d, wren_d, busy_d, done_d, err_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [COLOR_W-1:0] data_d;
   logic [CRD_W-1:0]   nx, ny;
   logic               start, range_bad;
   logic [CRD_W-1:0]   n_x_lo, n_x_hi, n_y_lo, n_y_hi;

`ifdef GRID_DRAW_OUTLINE_EN
   logic outline_q, outline_d;

   function automatic logic on_edge(input logic [CRD_W-1:0] x, y, xl, xh, yl, yh);
      return (x == xl) || (x == xh) || (y == yl) || (y == yh);
   endfunction
`endif

   // Corner normalisation: swapped corners describe the same rectangle.
   assign n_x_lo = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
   assign n_x_hi = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
   assign n_y_lo = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
   assign n_y_hi = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;

   assign range_bad = (32'(cmd_x0) >= GRID_W) || (32'(cmd_x1) >= GRID_W) ||
                      (32'(cmd_y0) >= GRID_H) || (32'(cmd_y1) >= GRID_H);

   // Next scan position: x wraps from x_hi back to x_lo and steps y.
   assign nx = (x_q == x_hi_q) ? x_lo_q : x_q + CRD_W'(1);
   assign ny = (x_q == x_hi_q) ? y_q + CRD_W'(1) : y_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      x_lo_d  = x_lo_q;
      x_hi_d  = x_hi_q;
      y_lo_d  = y_lo_q;
      y_hi_d  = y_hi_q;
      ready_d = cmd_ready;
      wren_d  = 1'b0;
      addr_d  = wraddress_gridData;
      data_d  = data_gridData;
      busy_d  = busy;
      done_d  = 1'b0;
      err_d   = 1'b0;
      start   = 1'b0;
`ifdef GRID_DRAW_OUTLINE_EN
      outline_d = outline_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (cmd_valid && cmd_ready) begin
               x_lo_d = n_x_lo;
               x_hi_d = n_x_hi;
               y_lo_d = n_y_lo;
               y_hi_d = n_y_hi;
`ifdef GRID_DRAW_OUTLINE_EN
               outline_d = 1'b0;
`endif
               case (op_t'(cmd_op))
                  OP_CLEAR: begin
                     x_lo_d = '0;
                     x_hi_d = X_MAX;
                     y_lo_d = '0;
                     y_hi_d = Y_MAX;
                     start  = 1'b1;
                  end
                  OP_SET: begin
                     x_lo_d = cmd_x0;
                     x_hi_d = cmd_x0;
                     y_lo_d = cmd_y0;
                     y_hi_d = cmd_y0;
                     err_d  = range_bad;
                     start  = !range_bad;
                  end
                  OP_FILL: begin
                     err_d = range_bad;
                     start = !range_bad;
                  end
                  default: begin
`ifdef GRID_DRAW_OUTLINE_EN
                     outline_d = 1'b1;
                     err_d     = range_bad;
                     start     = !range_bad;
`else
                     // NOP: done next cycle, and ready drops for that cycle.
                     done_d  = 1'b1;
                     ready_d = 1'b0;
`endif
                  end
               endcase

               if (start) begin
                  // The first scanned cell is always written: it is a corner.
                  state_d = S_DRAW;
                  x_d     = x_lo_d;
                  y_d     = y_lo_d;
                  wren_d  = 1'b1;
                  addr_d  = cell_addr(x_lo_d, y_lo_d);
                  data_d  = cmd_color;
                  busy_d  = 1'b1;
                  ready_d = 1'b0;
               end
            end
         end

         S_DRAW: begin
            if ((x_q == x_hi_q) && (y_q == y_hi_q)) begin
               // Last cell was presented this cycle; ready again with done.
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               x_d    = nx;
               y_d    = ny;
               addr_d = cell_addr(nx, ny);
`ifdef GRID_DRAW_OUTLINE_EN
               wren_d = !outline_q || on_edge(nx, ny, x_lo_q, x_hi_q, y_lo_q, y_hi_q);
`else
               wren_d = 1'b1;
`endif
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q            <= S_IDLE;
         x_q                <= '0;
         y_q                <= '0;
         x_lo_q             <= '0;
         x_hi_q             <= '0;
         y_lo_q             <= '0;
         y_hi_q             <= '0;
         cmd_ready          <= 1'b1;
         wren_gridData      <= 1'b0;
         wraddress_gridData <= '0;
         data_gridData      <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         cmd_err            <= 1'b0;
`ifdef GRID_DRAW_OUTLINE_EN
         outline_q          <= 1'b0;
`endif
      end else begin
         state_q            <= state_d;
         x_q                <= x_d;
         y_q                <= y_d;
         x_lo_q             <= x_lo_d;
         x_hi_q             <= x_hi_d;
         y_lo_q             <= y_lo_d;
         y_hi_q             <= y_hi_d;
         cmd_ready          <= ready_d;
         wren_gridData      <= wren_d;
         wraddress_gridData <= addr_d;
         data_gridData      <= data_d;
         busy               <= busy_d;
         done               <= done_d;
         cmd_err            <= err_d;
`ifdef GRID_DRAW_OUTLINE_EN
         outline_q          <= outline_d;
`endif
      end
   end

endmodule

// File: tb/tb_grid_draw_engine.sv
// ---------------------------------------------------------------------------
// tb_grid_draw_engine
//
// Self-checking bench for grid_draw_engine. A reference model turns each
// command into the list of cells the engine must scan (with a write flag
// per cell), and every cycle after accept is compared against that list.
// Directed commands are followed by randomized ones.
// ---------------------------------------------------------------------------
module tb_grid_draw_engine;

   localparam int GW = 64;
   localparam int GH = 48;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [5:0]  cmd_x0 = '0, cmd_x1 = '0, cmd_y0 = '0, cmd_y1 = '0;
   logic [3:0]  cmd_color = '0;
   logic        wren_gridData;
   logic [11:0] wraddress_gridData;
   logic [3:0]  data_gridData;
   logic        busy, done, cmd_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit we;
      int addr;
   } cell_t;

   cell_t exp_q[$];

   grid_draw_engine dut (
      .clock              (clock),
      .reset              (reset),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_op             (cmd_op),
      .cmd_x0             (cmd_x0),
      .cmd_x1             (cmd_x1),
      .cmd_y0             (cmd_y0),
      .cmd_y1             (cmd_y1),
      .cmd_color          (cmd_color),
      .wren_gridData      (wren_gridData),
      .wraddress_gridData (wraddress_gridData),
      .data_gridData      (data_gridData),
      .busy               (busy),
      .done               (done),
      .cmd_err            (cmd_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: the ordered list of cells a command scans.
   task automatic build_model(input logic [1:0] op, input int x0, x1, y0, y1,
                              output bit rej, output bit nop);
      int  xl, xh, yl, yh;
      bit  outl;
      exp_q.delete();
      rej = 0;
      nop = 0;
      if (op == 2'b00) begin
         for (int a = 0; a < GW * GH; a++) exp_q.push_back('{1'b1, a});
         return;
      end
`ifndef GRID_DRAW_OUTLINE_EN
      if (op == 2'b11) begin
         nop = 1;
         return;
      end
`endif
      if (x0 >= GW || x1 >= GW || y0 >= GH || y1 >= GH) begin
         rej = 1;
         return;
      end
      if (op == 2'b01) begin
         exp_q.push_back('{1'b1, y0 * GW + x0});
         return;
      end
      xl = (x0 < x1) ? x0 : x1;
      xh = (x0 < x1) ? x1 : x0;
      yl = (y0 < y1) ? y0 : y1;
      yh = (y0 < y1) ? y1 : y0;
      outl = (op == 2'b11);
      for (int y = yl; y <= yh; y++)
         for (int x = xl; x <= xh; x++)
            exp_q.push_back('{!outl || x == xl || x == xh || y == yl || y == yh, y * GW + x});
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (!cmd_ready && guard < 4000) begin
         @(negedge clock);
         guard++;
      end
      check("ready_before_cmd", cmd_ready, 1);
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] x0, x1, y0, y1,
                        input logic [3:0] color);
      cmd_op    = op;
      cmd_x0    = x0;
      cmd_x1    = x1;
      cmd_y0    = y0;
      cmd_y1    = y1;
      cmd_color = color;
   endtask

   // Called at the negedge of the cycle after the accept edge.
   task automatic expect_resp(input string name, input logic [3:0] color,
                              input bit rej, input bit nop);
      if (rej) begin
         check({name, ".err"},   cmd_err, 1);
         check({name, ".wren"},  wren_gridData, 0);
         check({name, ".done"},  done, 0);
         check({name, ".ready"}, cmd_ready, 1);
         @(negedge clock);
         check({name, ".err_end"},  cmd_err, 0);
         check({name, ".done_end"}, done, 0);
         return;
      end
      if (nop) begin
         check({name, ".done"},  done, 1);
         check({name, ".ready"}, cmd_ready, 0);
         check({name, ".busy"},  busy, 0);
         check({name, ".wren"},  wren_gridData, 0);
         @(negedge clock);
         check({name, ".ready_after"}, cmd_ready, 1);
         check({name, ".done_after"},  done, 0);
         return;
      end
      foreach (exp_q[i]) begin
         if (i > 0) @(negedge clock);
         check({name, ".wren"}, wren_gridData, exp_q[i].we);
         if (exp_q[i].we) begin
            check({name, ".addr"}, wraddress_gridData, exp_q[i].addr);
            check({name, ".data"}, data_gridData, color);
         end
         check({name, ".busy"},  busy, 1);
         check({name, ".ready"}, cmd_ready, 0);
         check({name, ".done"},  done, 0);
         check({name, ".err"},   cmd_err, 0);
      end
      @(negedge clock);
      check({name, ".done_pulse"}, done, 1);
      check({name, ".done_busy"},  busy, 0);
      check({name, ".done_wren"},  wren_gridData, 0);
      check({name, ".done_ready"}, cmd_ready, 1);
   endtask

   task automatic run_cmd(input string name, input logic [1:0] op,
                          input logic [5:0] x0, x1, y0, y1, input logic [3:0] color);
      bit rej, nop;
      wait_ready();
      drive(op, x0, x1, y0, y1, color);
      cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      build_model(op, int'(x0), int'(x1), int'(y0), int'(y1), rej, nop);
      expect_resp(name, color, rej, nop);
   endtask

   initial begin
      bit rej, nop;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst.ready", cmd_ready, 1);
      check("rst.wren",  wren_gridData, 0);
      check("rst.addr",  wraddress_gridData, 0);
      check("rst.data",  data_gridData, 0);
      check("rst.busy",  busy, 0);
      check("rst.done",  done, 0);
      check("rst.err",   cmd_err, 0);
      reset = 1'b0;
      @(negedge clock);

      // Directed commands
      run_cmd("set_5_3",   2'b01, 6'd5, 6'd0, 6'd3, 6'd0, 4'hA);
      run_cmd("fill_swap", 2'b10, 6'd4, 6'd2, 6'd2, 6'd1, 4'h7);
      run_cmd("set_y48",   2'b01, 6'd5, 6'd5, 6'd48, 6'd3, 4'h1);
      run_cmd("op11",      2'b11, 6'd0, 6'd2, 6'd0, 6'd2, 4'h3);
      run_cmd("fill_row",  2'b10, 6'd63, 6'd60, 6'd47, 6'd47, 4'hF);

      // CLEAR with a SET queued behind it, cmd_valid held high throughout
      wait_ready();
      drive(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 4'h0);
      cmd_valid = 1'b1;
      @(negedge clock);
      drive(2'b01, 6'd9, 6'd9, 6'd7, 6'd7, 4'h5);
      build_model(2'b00, 0, 0, 0, 0, rej, nop);
      expect_resp("clear_b2b", 4'h0, rej, nop);
      @(negedge clock);
      cmd_valid = 1'b0;
      build_model(2'b01, 9, 9, 7, 7, rej, nop);
      expect_resp("set_b2b", 4'h5, rej, nop);

      // Reset during the 10th write of a CLEAR
      wait_ready();
      drive(2'b00, 6'd0, 6'd0, 6'd0, 6'd0, 4'h2);
      cmd_valid = 1'b1;
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clock);
         check("clr_rst.wren", wren_gridData, 1);
         check("clr_rst.addr", wraddress_gridData, i);
      end
      reset = 1'b1;
      @(negedge clock);
      check("clr_rst.wren_off", wren_gridData, 0);
      check("clr_rst.busy",     busy, 0);
      check("clr_rst.ready",    cmd_ready, 1);
      check("clr_rst.done",     done, 0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("clr_rst.no_done", done, 0);
         check("clr_rst.no_wren", wren_gridData, 0);
         check("clr_rst.idle",    cmd_ready, 1);
      end

      // Randomized commands
      for (int n = 0; n < 30; n++) begin
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         if (op == 2'b00 && $urandom_range(0, 3) != 0) op = 2'b10;
         repeat ($urandom_range(0, 2)) @(negedge clock);
         run_cmd($sformatf("rnd%0d_op%0d", n, op), op,
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 50)), 6'($urandom_range(0, 50)),
                 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
